// File: rtl/fsgn_pipe_if.sv
// Operand/result handshake bundle for the fsgn_pipe sign-injection pipeline.
// Ports:
//   flush, in_valid, x1, x2, funct, tag, out_ready -- driven by the master
//   in_ready, out_valid, y, y_tag, illegal         -- driven by the block (slave)
interface fsgn_pipe_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [2:0]  funct;
  logic [4:0]  tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [4:0]  y_tag;
  logic        illegal;

  modport master (
    output flush, in_valid, x1, x2, funct, tag, out_ready,
    input  in_ready, out_valid, y, y_tag, illegal
  );

  modport slave (
    input  flush, in_valid, x1, x2, funct, tag, out_ready,
    output in_ready, out_valid, y, y_tag, illegal
  );
endinterface

// File: rtl/fsgn_pipe.sv
// fsgn_pipe: two-stage valid/ready pipeline for the FP sign-injection ops
// (fsgnj, fsgnjn, fsgnjx, fneg, fabs). Only bit 31 of x1 is ever altered.
// Ports:
//   clk  -- rising-edge clock
//   rst  -- synchronous active-high reset
//   bus  -- fsgn_pipe_if.slave: operand beat in, result beat out, flush
module fsgn_pipe (
  input  logic          clk,
  input  logic          rst,
  fsgn_pipe_if.slave    bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned FW = 3;
  localparam int unsigned TW = 5;

  logic          s1_valid;
  logic [DW-1:0] s1_x1;
  logic [DW-1:0] s1_x2;
  logic [FW-1:0] s1_funct;
  logic [TW-1:0] s1_tag;

  logic          s2_valid;
  logic [DW-1:0] y_q;
  logic [TW-1:0] y_tag_q;
  logic          illegal_q;

  logic          s1_adv;
  logic          s2_adv;
  logic          res_sign;
  logic          res_ill;
  logic [DW-1:0] res_y;

  // Stage advance chain; ready is combinational from out_ready.
  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // A flush empties both stages, so the block can always take a beat then.
  assign bus.in_ready  = s1_adv || bus.flush;
  assign bus.out_valid = s2_valid;
  assign bus.y         = y_q;
  assign bus.y_tag     = y_tag_q;
  assign bus.illegal   = illegal_q;

  // Sign selection; unknown functs pass x1 through untouched.
  always_comb begin
    res_sign = s1_x1[DW-1];
    res_ill  = 1'b0;
    case (s1_funct)
      3'b000:  res_sign = s1_x2[DW-1];
      3'b001:  res_sign = ~s1_x2[DW-1];
      3'b010:  res_sign = s1_x1[DW-1] ^ s1_x2[DW-1];
      3'b011:  res_sign = ~s1_x1[DW-1];
      3'b100:  res_sign = 1'b0;
      default: res_ill  = 1'b1;
    endcase
    res_y = {res_sign, s1_x1[DW-2:0]};
  end

  // Stage valids: reset beats flush, flush beats advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= bus.in_valid;
      if (s2_adv) s2_valid <= s1_valid;
    end
  end

  // Data registers load only when a real beat moves into the stage,
  // so outputs hold steady under backpressure and stay X-free after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_x1     <= '0;
      s1_x2     <= '0;
      s1_funct  <= '0;
      s1_tag    <= '0;
      y_q       <= '0;
      y_tag_q   <= '0;
      illegal_q <= 1'b0;
    end else if (!bus.flush) begin
      if (s1_adv && bus.in_valid) begin
        s1_x1    <= bus.x1;
        s1_x2    <= bus.x2;
        s1_funct <= bus.funct;
        s1_tag   <= bus.tag;
      end
      if (s2_adv && s1_valid) begin
        y_q       <= res_y;
        y_tag_q   <= s1_tag;
        illegal_q <= res_ill;
      end
    end
  end

endmodule

// File: tb/tb_fsgn_pipe.sv
// Self-checking bench for fsgn_pipe: directed scenarios followed by a long
// randomized run, all checked against a FIFO-level reference model.
module tb_fsgn_pipe;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fsgn_pipe_if bus ();

  fsgn_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: beats in flight, oldest first, with edges since acceptance.
  logic [31:0] q_y[$];
  logic [4:0]  q_tag[$];
  logic        q_ill[$];
  int          q_age[$];

  // Returns {illegal, y} from the instruction definition.
  function automatic logic [32:0] ref_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f);
    logic s;
    case (f)
      3'd0:    s = b[31];
      3'd1:    s = !b[31];
      3'd2:    s = (a[31] != b[31]);
      3'd3:    s = !a[31];
      3'd4:    s = 1'b0;
      default: return {1'b1, a};
    endcase
    return {1'b0, s, a[30:0]};
  endfunction

  task automatic clear_model();
    q_y.delete();
    q_tag.delete();
    q_ill.delete();
    q_age.delete();
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock cycle: drive, check at negedge, advance the model at posedge.
  // use_e supplies a hand-derived expected result instead of ref_fn.
  task automatic step(input logic fl, input logic iv, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] f, input logic [4:0] t,
                      input logic ordy, input logic use_e, input logic [31:0] ey,
                      input logic eill, output logic acc);
    logic        exp_ir;
    logic        exp_ov;
    logic [32:0] r;
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.x1        = a;
    bus.x2        = b;
    bus.funct     = f;
    bus.tag       = t;
    bus.out_ready = ordy;
    @(negedge clk);
    exp_ir = fl || (q_y.size() < 2) || ordy;
    exp_ov = (q_y.size() > 0) && (q_age[0] >= 1);
    chk1("in_ready", bus.in_ready, exp_ir);
    chk1("out_valid", bus.out_valid, exp_ov);
    if (exp_ov) begin
      chk32("y", bus.y, q_y[0]);
      chk32("y_tag", 32'(bus.y_tag), 32'(q_tag[0]));
      chk1("illegal", bus.illegal, q_ill[0]);
    end
    @(posedge clk);
    acc = iv && exp_ir && !fl;
    if (exp_ov && ordy) begin
      void'(q_y.pop_front());
      void'(q_tag.pop_front());
      void'(q_ill.pop_front());
      void'(q_age.pop_front());
    end
    foreach (q_age[i]) q_age[i]++;
    if (fl) clear_model();
    if (acc) begin
      r = ref_fn(a, b, f);
      q_y.push_back(use_e ? ey : r[31:0]);
      q_ill.push_back(use_e ? eill : r[32]);
      q_tag.push_back(t);
      q_age.push_back(0);
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 5'd0, ordy, 1'b0, 32'h0, 1'b0, acc);
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                      input logic [4:0] t, input logic ordy, input logic [31:0] ey,
                      input logic eill);
    logic acc;
    step(1'b0, 1'b1, a, b, f, t, ordy, 1'b1, ey, eill, acc);
    chk1("accepted", acc, 1'b1);
  endtask

  // Hold rst for n edges, release, then check the post-reset state.
  task automatic do_reset(input int n);
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk32("rst_y", bus.y, 32'h0);
    chk32("rst_y_tag", 32'(bus.y_tag), 32'h0);
    chk1("rst_illegal", bus.illegal, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    int   k;
    int   cyc;
    int   guard;
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x1        = '0;
    bus.x2        = '0;
    bus.funct     = '0;
    bus.tag       = '0;
    bus.out_ready = 1'b0;

    do_reset(3);

    // Single fneg, two-cycle latency
    beat(32'h3F800000, 32'h0, 3'b011, 5'd7, 1'b1, 32'hBF800000, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Back-to-back directed ops at full throughput
    beat(32'hC0000000, 32'h80000000, 3'b010, 5'd1, 1'b1, 32'h40000000, 1'b0);
    beat(32'hFF800000, 32'h12345678, 3'b100, 5'd2, 1'b1, 32'h7F800000, 1'b0);
    beat(32'h00000000, 32'h00000000, 3'b001, 5'd3, 1'b1, 32'h80000000, 1'b0);
    beat(32'h12345678, 32'hFFFFFFFF, 3'b111, 5'd4, 1'b1, 32'h12345678, 1'b1);
    beat(32'h7FC00001, 32'h80000000, 3'b000, 5'd5, 1'b1, 32'hFFC00001, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: four beats, out_ready low for the first three cycles
    k   = 0;
    cyc = 0;
    while (k < 4 && cyc < 50) begin
      step(1'b0, 1'b1, $urandom, $urandom, 3'(k), 5'(k + 10), (cyc >= 3), 1'b0,
           32'h0, 1'b0, acc);
      if (acc) k++;
      cyc++;
    end
    chk32("bp_beats_accepted", 32'(k), 32'd4);
    chk32("bp_cycles", 32'(cyc), 32'd5);
    repeat (3) idle(1'b1);

    // Flush with both stages full and out_ready low
    beat(32'h11111111, 32'h0, 3'b011, 5'd20, 1'b0, 32'h91111111, 1'b0);
    beat(32'h22222222, 32'h0, 3'b011, 5'd21, 1'b0, 32'hA2222222, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b1, 32'h33333333, 32'h0, 3'd0, 5'd22, 1'b0, 1'b0, 32'h0, 1'b0, acc);
    repeat (3) idle(1'b1);

    // Flush while a result is delivered in the same cycle
    beat(32'h44444444, 32'h0, 3'b100, 5'd23, 1'b1, 32'h44444444, 1'b0);
    beat(32'h55555555, 32'h0, 3'b100, 5'd24, 1'b1, 32'h55555555, 1'b0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b0, acc);
    repeat (2) idle(1'b1);

    // Reset mid-stream
    beat(32'h66666666, 32'h0, 3'b011, 5'd25, 1'b0, 32'hE6666666, 1'b0);
    beat(32'h77777777, 32'h0, 3'b011, 5'd26, 1'b0, 32'hF7777777, 1'b0);
    do_reset(1);
    repeat (2) idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      step(($urandom % 64) == 0, ($urandom % 4) != 0, $urandom, $urandom,
           3'($urandom % 8), 5'($urandom), ($urandom % 3) != 0, 1'b0, 32'h0, 1'b0, acc);
    end

    guard = 0;
    while (q_y.size() > 0 && guard < 20) begin
      idle(1'b1);
      guard++;
    end
    chk32("drain_left", 32'(q_y.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fsgn_pipe.md
FSGN_PIPE -- requirements
Module: fsgn_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
REQ-002 The block SHALL expose the following ports.
- flush      input   1   synchronous pipeline kill
- in_valid   input   1   operand beat valid
- in_ready   output  1   block can accept a beat this cycle
- x1         input   32  IEEE-754 single operand (magnitude source)
- x2         input   32  IEEE-754 single operand (sign source)
- funct      input   3   000 fsgnj, 001 fsgnjn, 010 fsgnjx, 011 fneg, 100 fabs
- tag        input   5   destination register id, passed through unchanged
- out_valid  output  1   result beat valid
- out_ready  input   1   consumer accepts result
- y          output  32  result
- y_tag      output  5   tag of result
- illegal    output  1   funct was 101/110/111
REQ-003 The block SHALL have no parameters.

Function
REQ-004 The block SHALL be a 2-stage pipeline: S1 registers x1, x2, funct and tag; S2 registers y, y_tag and illegal.
REQ-005 A beat SHALL transfer on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-006 The stage valids SHALL be derived as follows.
- s2_adv = !s2_valid || out_ready
- s1_adv = !s1_valid || s2_adv
- in_ready = s1_adv (combinational from out_ready; no registered ready)
REQ-007 Latency SHALL be 2 cycles with no backpressure: a beat accepted at edge N appears with out_valid=1 after edge N+1.
REQ-008 Throughput SHALL be 1 beat per cycle while out_ready=1.
REQ-009 While out_ready=0 with both stages full, in_ready SHALL be 0 and all S1/S2 contents SHALL hold unchanged.
REQ-010 y[30:0] SHALL equal x1[30:0] for every legal funct.
REQ-011 y[31] SHALL be computed per funct.
- fsgnj: x2[31]
- fsgnjn: ~x2[31]
- fsgnjx: x1[31]^x2[31]
- fneg: ~x1[31] (x2 ignored)
- fabs: 0 (x2 ignored)
REQ-012 For funct 101/110/111, y SHALL equal x1 unchanged and illegal SHALL be 1; otherwise illegal SHALL be 0.
REQ-013 NaN, infinity, zero and denormal inputs SHALL receive no special treatment; only bit 31 is altered.
REQ-014 When flush=1 at an edge, s1_valid and s2_valid SHALL become 0, the input beat of that cycle SHALL be discarded, and in_ready SHALL read 1 in the flush cycle.
REQ-015 flush SHALL take priority over out_ready; a beat presented with out_valid && out_ready in the flush cycle SHALL count as delivered.
REQ-016 y, y_tag and illegal SHALL be held stable while out_valid=1 && out_ready=0.
REQ-017 Data registers SHALL load only on stage advance; their values while the corresponding valid=0 are don't-care, but outputs SHALL never produce X after reset.

Reset
REQ-018 While rst=1 at an edge, s1_valid and s2_valid SHALL clear to 0 and y, y_tag and illegal SHALL clear to 0; out_valid SHALL read 0 in the following cycle.
REQ-019 rst SHALL take priority over flush and in_valid, and a beat in flight at reset SHALL be lost.
REQ-020 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-021 Single fneg: x1=32'h3F800000, funct=011, tag=7, out_ready=1 -> two cycles later y=32'hBF800000, y_tag=7, illegal=0.
REQ-022 fsgnjx: x1=32'hC0000000, x2=32'h80000000 -> y=32'h40000000; fabs of 32'hFF800000 -> 32'h7F800000; fsgnjn of x1=0, x2=0 -> 32'h80000000.
REQ-023 Backpressure: stream 4 beats with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted beats, y held stable, then all 4 results emerge in order with matching tags and no loss or duplication.
REQ-024 Illegal funct=111, x1=32'h12345678 -> y=32'h12345678, illegal=1.
REQ-025 Flush/reset: with both stages full and out_ready=0, assert flush -> out_valid=0 next cycle and no stale result appears; repeat with rst mid-stream -> all outputs 0 and in_ready=1 after release.
REQ-026 Random: 10000 random x1, x2, funct, tag with random out_ready -> compare against a reference model per REQ-010..REQ-012.
